mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- EX-stage multiply/divide unit for the P5 MIPS pipeline.
- Sits beside the ALU and consumes the same forwarded EX operands (A = rs value, B = rt value).
- Holds the architectural HI/LO registers and models multi-cycle mult/div latency with a Busy flag.
- The hazard unit uses Start|Busy to stall ID; the EX/MEM result mux reads HI/LO for mfhi/mflo.

Parameters:
MULT_CYCLES, 5, cycles from Start to HI/LO update for mult/multu (>=1)
DIV_CYCLES, 10, cycles from Start to HI/LO update for div/divu (>=1)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous active-high reset
A  input  32  operand 1 (rs, forwarded)
B  input  32  operand 2 (rt, forwarded)
MDOp  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others reserved
Start  input  1  one-cycle strobe: EX holds an MD instruction
Busy  output  1  operation in flight
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- One clock (clk); reset is synchronous, active-high, sampled on the rising edge of clk.
- On reset: HI=0, LO=0, Busy=0, cycle counter=0, pending results cleared. Reset overrides Start in the same cycle.
- Reset during an operation aborts it. HI/LO take 0 and no later update occurs.
- An op is accepted at edge k when Start=1, Busy=0 and reset=0.
- mult/multu (000/001): 64-bit product of A and B, signed or unsigned. HI=product[63:32], LO=product[31:0].
- div/divu (010/011): LO=quotient, HI=remainder.
  - Signed div truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0, with no trap.
- Divide by zero (B=0): the op still runs the full DIV_CYCLES with Busy high. HI/LO keep their prior values at completion.
- Results are computed from A/B captured at edge k and held in internal pending registers. Later changes on A/B have no effect.
- Busy rises at edge k and stays high for exactly N cycles (N=MULT_CYCLES or DIV_CYCLES).
- At edge k+N, HI/LO take the pending results and Busy falls at the same edge. HI/LO are never visible early.
- mthi/mtlo (100/101): with Busy=0, HI or LO takes A at edge k. Busy stays 0 and the other register is unchanged.
- Start while Busy=1: ignored, with no effect on the counter, pending results or HI/LO. The hazard unit guarantees this does not occur; the ignore behaviour is the required fallback.
- Start with a reserved MDOp: no-op; Busy stays 0.
- Start arriving on the same edge Busy falls: still counts as Start while Busy=1 and is ignored. Back-to-back ops require Start in the cycle after Busy=0 is visible.
- HI/LO are registered outputs, readable every cycle. During Busy they show the previous values.
- Counter width must cover max(MULT_CYCLES, DIV_CYCLES).

Test Plan:
- Reset, then mult with A=0xFFFFFFFF, B=2 -> Busy high for 5 cycles; at edge k+5, HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div with A=0xFFFFFFF9 (-7), B=2 -> Busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- Divide by zero: mthi 0x1234, then mtlo 0x5678, then div with B=0 -> Busy high for 10 cycles; HI=0x1234 and LO=0x5678 unchanged.
- Start mult (A=3, B=4), then during Busy pulse Start with div (A=100, B=7) and mthi 0xDEAD -> both ignored; at completion HI=0, LO=12.
- Start div (A=100, B=7); assert reset at cycle 4 -> HI=0, LO=0, Busy=0 next edge; no update at cycle 10.
- Overflow corner: div with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. Then mtlo 0xABCD the cycle after Busy falls -> LO=0xABCD at the next edge, Busy stays 0.

Source files
------------

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: architectural HI/LO registers with a
// Busy flag that models multi-cycle mult/div latency for the hazard unit.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t        state_r, state_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic [31:0]   pend_hi_r, pend_hi_n;
  logic [31:0]   pend_lo_r, pend_lo_n;
  logic          pend_wr_r, pend_wr_n;
  logic [31:0]   hi_r, hi_n;
  logic [31:0]   lo_r, lo_n;
  logic          busy_r;
  logic [63:0]   prod_s;
  logic [63:0]   quot_rem_s;

  // Full 64-bit product; sign-extending both operands keeps the low 64 bits exact.
  function automatic logic [63:0] mul_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    ext_a = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    ext_b = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    return ext_a * ext_b;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so
  // 0x80000000 / -1 wraps back to 0x80000000 without a special case.
  function automatic logic [63:0] div_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    neg_a   = is_signed & a[31];
    neg_b   = is_signed & b[31];
    mag_a   = neg_a ? (32'd0 - a) : a;
    mag_b   = neg_b ? (32'd0 - b) : b;
    divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q       = mag_a / divisor;
    r       = mag_a % divisor;
    q       = (neg_a ^ neg_b) ? (32'd0 - q) : q;
    r       = neg_a ? (32'd0 - r) : r;
    return {r, q};
  endfunction

  // Next-state, counter, pending-result and HI/LO update logic.
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    pend_hi_n  = pend_hi_r;
    pend_lo_n  = pend_lo_r;
    pend_wr_n  = pend_wr_r;
    hi_n       = hi_r;
    lo_n       = lo_r;
    prod_s     = mul_calc(A, B, MDOp == OP_MULT);
    quot_rem_s = div_calc(A, B, MDOp == OP_DIV);

    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          case (MDOp)
            OP_MULT, OP_MULTU: begin
              pend_hi_n = prod_s[63:32];
              pend_lo_n = prod_s[31:0];
              pend_wr_n = 1'b1;
              cnt_n     = MULT_LOAD;
              state_n   = ST_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor still occupies the unit but leaves HI/LO alone.
              pend_hi_n = quot_rem_s[63:32];
              pend_lo_n = quot_rem_s[31:0];
              pend_wr_n = (B != 32'd0);
              cnt_n     = DIV_LOAD;
              state_n   = ST_BUSY;
            end
            OP_MTHI: hi_n = A;
            OP_MTLO: lo_n = A;
            default: state_n = ST_IDLE;
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == CNT_ONE) begin
          state_n   = ST_IDLE;
          cnt_n     = CNT_ZERO;
          pend_wr_n = 1'b0;
          if (pend_wr_r) begin
            hi_n = pend_hi_r;
            lo_n = pend_lo_r;
          end else begin
            hi_n = hi_r;
            lo_n = lo_r;
          end
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = CNT_ZERO;
      end
    endcase
  end

  // State and architectural registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      pend_hi_r <= pend_hi_n;
      pend_lo_r <= pend_lo_n;
      pend_wr_r <= pend_wr_n;
      hi_r      <= hi_n;
      lo_r      <= lo_n;
      busy_r    <= (state_n == ST_BUSY);
    end
  end

  assign Busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit; each task checks {Busy,HI,LO}
// cycle by cycle against hand-computed values.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors;
  int miscompares;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .MDOp (MDOp),
    .Start(Start),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one Start strobe, then scrambles A/B to prove operand capture.
  task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp  = op;
    A     = a;
    B     = b;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    A     = 32'hA5A5_5A5A;
    B     = 32'h0000_0003;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Start = 1'b1;
    MDOp  = OP_MULT;
    A     = 32'd7;
    B     = 32'd9;
    tick();
    tick();
    Start = 1'b0;
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset: got Busy=%b HI=%h LO=%h, expected 0/00000000/00000000", Busy, HI, LO);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_release: got Busy=%b HI=%h LO=%h, expected idle zeros", Busy, HI, LO);
    end
  endtask

  task automatic test_mult();
    pulse(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < MC; i++) begin
      vectors++;
      if ({Busy, HI, LO} !== {1'b1, 32'd0, 32'd0}) begin
        miscompares++;
        $display("FAIL mult_busy[%0d]: got Busy=%b HI=%h LO=%h, expected 1/0/0", i, Busy, HI, LO);
      end
      if (i < MC - 1) tick();
    end
    tick();
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE}) begin
      miscompares++;
      $display("FAIL mult_result: got Busy=%b HI=%h LO=%h, expected 0/ffffffff/fffffffe", Busy, HI, LO);
    end
    pulse(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < MC; i++) begin
      vectors++;
      if ({Busy, HI, LO} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE}) begin
        miscompares++;
        $display("FAIL multu_busy[%0d]: got Busy=%b HI=%h LO=%h, expected prior values", i, Busy, HI, LO);
      end
      if (i < MC - 1) tick();
    end
    tick();
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'h0000_0001, 32'hFFFF_FFFE}) begin
      miscompares++;
      $display("FAIL multu_result: got Busy=%b HI=%h LO=%h, expected 0/00000001/fffffffe", Busy, HI, LO);
    end
  endtask

  task automatic test_div();
    pulse(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < DC; i++) begin
      vectors++;
      if ({Busy, HI, LO} !== {1'b1, 32'h0000_0001, 32'hFFFF_FFFE}) begin
        miscompares++;
        $display("FAIL div_busy[%0d]: got Busy=%b HI=%h LO=%h, expected prior values", i, Busy, HI, LO);
      end
      if (i < DC - 1) tick();
    end
    tick();
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      miscompares++;
      $display("FAIL div_result: got Busy=%b HI=%h LO=%h, expected 0/ffffffff/fffffffd", Busy, HI, LO);
    end
    pulse(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < DC; i++) begin
      vectors++;
      if (Busy !== 1'b1) begin
        miscompares++;
        $display("FAIL divu_busy[%0d]: got Busy=%b expected 1", i, Busy);
      end
      if (i < DC - 1) tick();
    end
    tick();
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'h0000_0001, 32'h7FFF_FFFC}) begin
      miscompares++;
      $display("FAIL divu_result: got Busy=%b HI=%h LO=%h, expected 0/00000001/7ffffffc", Busy, HI, LO);
    end
  endtask

  task automatic test_div_zero();
    pulse(OP_MTHI, 32'h0000_1234, 32'd0);
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'h0000_1234, 32'h7FFF_FFFC}) begin
      miscompares++;
      $display("FAIL mthi: got Busy=%b HI=%h LO=%h, expected 0/00001234/7ffffffc", Busy, HI, LO);
    end
    pulse(OP_MTLO, 32'h0000_5678, 32'd0);
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'h0000_1234, 32'h0000_5678}) begin
      miscompares++;
      $display("FAIL mtlo: got Busy=%b HI=%h LO=%h, expected 0/00001234/00005678", Busy, HI, LO);
    end
    pulse(OP_DIV, 32'd55, 32'd0);
    for (int i = 0; i < DC; i++) begin
      vectors++;
      if ({Busy, HI, LO} !== {1'b1, 32'h0000_1234, 32'h0000_5678}) begin
        miscompares++;
        $display("FAIL divzero_busy[%0d]: got Busy=%b HI=%h LO=%h, expected 1/00001234/00005678", i, Busy, HI, LO);
      end
      if (i < DC - 1) tick();
    end
    tick();
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'h0000_1234, 32'h0000_5678}) begin
      miscompares++;
      $display("FAIL divzero_result: got Busy=%b HI=%h LO=%h, expected 0/00001234/00005678", Busy, HI, LO);
    end
  endtask

  task automatic test_ignore_while_busy();
    pulse(OP_MULT, 32'd3, 32'd4);
    pulse(OP_DIV, 32'd100, 32'd7);
    pulse(OP_MTHI, 32'h0000_DEAD, 32'd0);
    vectors++;
    if ({Busy, HI, LO} !== {1'b1, 32'h0000_1234, 32'h0000_5678}) begin
      miscompares++;
      $display("FAIL ignore_mid: got Busy=%b HI=%h LO=%h, expected 1/00001234/00005678", Busy, HI, LO);
    end
    tick();
    tick();
    // Start on the edge where Busy falls must also be dropped.
    pulse(OP_MTLO, 32'h0000_0999, 32'd0);
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'd0, 32'd12}) begin
      miscompares++;
      $display("FAIL ignore_result: got Busy=%b HI=%h LO=%h, expected 0/00000000/0000000c", Busy, HI, LO);
    end
    tick();
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'd0, 32'd12}) begin
      miscompares++;
      $display("FAIL ignore_after: got Busy=%b HI=%h LO=%h, expected 0/00000000/0000000c", Busy, HI, LO);
    end
    pulse(3'b110, 32'h1111_1111, 32'd1);
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'd0, 32'd12}) begin
      miscompares++;
      $display("FAIL reserved_op: got Busy=%b HI=%h LO=%h, expected 0/00000000/0000000c", Busy, HI, LO);
    end
  endtask

  task automatic test_reset_abort();
    pulse(OP_DIV, 32'd100, 32'd7);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL abort_reset: got Busy=%b HI=%h LO=%h, expected 0/0/0", Busy, HI, LO);
    end
    for (int i = 0; i < DC; i++) begin
      tick();
      vectors++;
      if ({Busy, HI, LO} !== {1'b0, 32'd0, 32'd0}) begin
        miscompares++;
        $display("FAIL abort_after[%0d]: got Busy=%b HI=%h LO=%h, expected 0/0/0", i, Busy, HI, LO);
      end
    end
  endtask

  task automatic test_back_to_back();
    pulse(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < DC - 1; i++) tick();
    vectors++;
    if ({Busy, HI, LO} !== {1'b1, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL ovf_last_busy: got Busy=%b HI=%h LO=%h, expected 1/0/0", Busy, HI, LO);
    end
    tick();
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'd0, 32'h8000_0000}) begin
      miscompares++;
      $display("FAIL ovf_result: got Busy=%b HI=%h LO=%h, expected 0/00000000/80000000", Busy, HI, LO);
    end
    pulse(OP_MTLO, 32'h0000_ABCD, 32'd0);
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'd0, 32'h0000_ABCD}) begin
      miscompares++;
      $display("FAIL b2b_mtlo: got Busy=%b HI=%h LO=%h, expected 0/00000000/0000abcd", Busy, HI, LO);
    end
    pulse(OP_MULTU, 32'h0001_0000, 32'h0003_0000);
    vectors++;
    if ({Busy, HI, LO} !== {1'b1, 32'd0, 32'h0000_ABCD}) begin
      miscompares++;
      $display("FAIL b2b_mult_start: got Busy=%b HI=%h LO=%h, expected 1/00000000/0000abcd", Busy, HI, LO);
    end
    for (int i = 0; i < MC; i++) tick();
    vectors++;
    if ({Busy, HI, LO} !== {1'b0, 32'h0000_0003, 32'd0}) begin
      miscompares++;
      $display("FAIL b2b_mult_result: got Busy=%b HI=%h LO=%h, expected 0/00000003/00000000", Busy, HI, LO);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    Start       = 1'b0;
    MDOp        = 3'b000;
    A           = 32'd0;
    B           = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_while_busy();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
